// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLLE2 DRP reconfiguration controller.
// Holds the FSM state encoding, the error codes and the DRP register map.
package pll_drp_pkg;

  localparam int DrpAddrW = 7;
  localparam int DrpDataW = 16;

  localparam logic [DrpAddrW-1:0] ClkOut0Reg1  = 7'h08;
  localparam logic [DrpAddrW-1:0] ClkOut0Reg2  = 7'h09;
  localparam logic [DrpAddrW-1:0] ClkFbOutReg1 = 7'h14;
  localparam logic [DrpAddrW-1:0] ClkFbOutReg2 = 7'h15;

  typedef enum logic [3:0] {
    StIdle,
    StHoldRst,
    StRd,
    StRdWait,
    StWr,
    StWrWait,
    StRelease,
    StWaitLock,
    StDone,
    StError
  } drp_state_e;

  typedef enum logic [1:0] {
    ErrNone        = 2'd0,
    ErrDrdyTimeout = 2'd1,
    ErrLockTimeout = 2'd2
  } err_code_e;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for slow level signals crossing into clk_i.
// Both stages clear on the asynchronous reset.
module prim_flop_2sync #(
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/pll_drp_reconfig_ctrl.sv
// PLLE2 DRP reconfiguration sequencer: holds the PLL in reset, applies
// read-modify-write updates from a config table, then waits for relock.
module pll_drp_reconfig_ctrl
  import pll_drp_pkg::*;
#(
  parameter int NumRegs       = 4,
  parameter int RstHoldCycles = 4,
  parameter int DrdyTimeout   = 64,
  parameter int LockTimeout   = 100000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [NumRegs*DrpAddrW-1:0]  cfg_addr_i,
  input  logic [NumRegs*DrpDataW-1:0]  cfg_mask_i,
  input  logic [NumRegs*DrpDataW-1:0]  cfg_data_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [1:0]                   err_code_o,
  output logic                         locked_o,
  output logic [DrpAddrW-1:0]          drp_daddr_o,
  output logic                         drp_den_o,
  output logic                         drp_dwe_o,
  output logic [DrpDataW-1:0]          drp_di_o,
  input  logic [DrpDataW-1:0]          drp_do_i,
  input  logic                         drp_drdy_i,
  output logic                         pll_rst_o,
  input  logic                         pll_locked_i
);

  localparam int CntW =
    $clog2(max3(RstHoldCycles, DrdyTimeout, LockTimeout)) + 1;
  localparam int IdxW = $clog2(NumRegs) + 1;

  drp_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                err_q, err_d;
  err_code_e           code_q, code_d;
  logic [DrpAddrW-1:0] daddr_q;
  logic [DrpDataW-1:0] di_q;
  logic                lock_s;

  logic [DrpAddrW-1:0] sel_addr;
  logic [DrpDataW-1:0] sel_mask;
  logic [DrpDataW-1:0] sel_data;
  logic [DrpDataW-1:0] merged;

  prim_flop_2sync #(
    .Width(1)
  ) u_lock_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (pll_locked_i),
    .q_o  (lock_s)
  );

  // Table lookup follows the next index so the address is ready with den.
  assign sel_addr = cfg_addr_i[int'(idx_d)*DrpAddrW +: DrpAddrW];
  assign sel_mask = cfg_mask_i[int'(idx_d)*DrpDataW +: DrpDataW];
  assign sel_data = cfg_data_i[int'(idx_d)*DrpDataW +: DrpDataW];
  assign merged   = (drp_do_i & sel_mask) | (sel_data & ~sel_mask);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StHoldRst;
          cnt_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          code_d  = ErrNone;
        end
      end
      StHoldRst: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(RstHoldCycles - 1)) state_d = StRd;
      end
      StRd: begin
        state_d = StRdWait;
        cnt_d   = '0;
      end
      StRdWait: begin
        if (drp_drdy_i) begin
          state_d = StWr;
        end else if (cnt_q == CntW'(DrdyTimeout - 1)) begin
          state_d = StError;
          err_d   = 1'b1;
          code_d  = ErrDrdyTimeout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWr: begin
        state_d = StWrWait;
        cnt_d   = '0;
      end
      StWrWait: begin
        if (drp_drdy_i) begin
          if (idx_q == IdxW'(NumRegs - 1)) begin
            state_d = StRelease;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRd;
          end
        end else if (cnt_q == CntW'(DrdyTimeout - 1)) begin
          state_d = StError;
          err_d   = 1'b1;
          code_d  = ErrDrdyTimeout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StDone;
        end else if (cnt_q == CntW'(LockTimeout - 1)) begin
          state_d = StError;
          err_d   = 1'b1;
          code_d  = ErrLockTimeout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ErrNone;
      daddr_q <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      code_q  <= code_d;
      if (state_d == StRd || state_d == StWr) daddr_q <= sel_addr;
      if (state_d == StWr) di_q <= merged;
    end
  end

  assign busy_o      = !(state_q inside {StIdle, StDone, StError});
  assign done_o      = state_q inside {StDone, StError};
  assign pll_rst_o   = state_q inside {StHoldRst, StRd, StRdWait,
                                       StWr, StWrWait};
  assign drp_den_o   = state_q inside {StRd, StWr};
  assign drp_dwe_o   = (state_q == StWr);
  assign drp_daddr_o = daddr_q;
  assign drp_di_o    = di_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;
  assign locked_o    = lock_s & ~busy_o;

endmodule

// File: tb/tb_pll_drp_reconfig_ctrl.sv
// Self-checking bench for pll_drp_reconfig_ctrl with a DRP slave model,
// a PLL lock model and a transaction-level reference of the update table.
module tb_pll_drp_reconfig_ctrl;

  localparam int NR = 4;
  localparam int RH = 4;
  localparam int DT = 64;
  localparam int LT = 400;

  typedef struct packed {
    logic        we;
    logic [6:0]  a;
    logic [15:0] d;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_drv = 1'b0;
  logic spam = 1'b0;
  logic stray = 1'b0;
  logic model_drdy = 1'b0;
  logic pll_lk = 1'b0;
  logic start, drdy;
  logic [NR*7-1:0]  cfg_addr = '0;
  logic [NR*16-1:0] cfg_mask = '0;
  logic [NR*16-1:0] cfg_data = '0;
  logic busy, done, err, den, dwe, pll_rst, locked;
  logic [1:0]  code;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] do_q = '0;

  assign start = start_drv | (spam & busy);
  assign drdy  = model_drdy | stray;

  pll_drp_reconfig_ctrl #(
    .NumRegs(NR), .RstHoldCycles(RH),
    .DrdyTimeout(DT), .LockTimeout(LT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cfg_addr_i(cfg_addr), .cfg_mask_i(cfg_mask), .cfg_data_i(cfg_data),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(code),
    .locked_o(locked), .drp_daddr_o(daddr), .drp_den_o(den),
    .drp_dwe_o(dwe), .drp_di_o(di), .drp_do_i(do_q),
    .drp_drdy_i(drdy), .pll_rst_o(pll_rst), .pll_locked_i(pll_lk)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int pend = 0;
  int lat = 3;
  int rd_n = 0;
  int hang_rd = -1;
  int hang_cyc = -1;
  int done_cyc = -1;
  int rel_cyc = -1;
  int den_viol = 0;
  int dwe_viol = 0;
  int done_n = 0;
  int hold_n = 0;
  int hold_at_den = -1;
  int lk = 0;
  int lock_dly = 10;
  bit lock_en = 1'b1;
  logic prev_den = 1'b0;
  logic prev_rst = 1'b0;
  logic err_at_start = 1'b0;
  logic [15:0] mem [128];
  txn_t log_q[$];
  txn_t exp_q[$];

  // DRP slave, PLL lock behaviour and protocol monitor, all on negedge
  always @(negedge clk) begin
    txn_t t;
    cyc++;
    if (den && prev_den) den_viol++;
    if (dwe && !den) dwe_viol++;
    if (done) begin
      done_n++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (prev_rst && !pll_rst && rel_cyc < 0) rel_cyc = cyc;
    if (den && hold_at_den < 0) hold_at_den = hold_n;
    else if (pll_rst && hold_at_den < 0) hold_n++;
    prev_den = den;
    prev_rst = pll_rst;
    model_drdy = 1'b0;
    if (rst) pend = 0;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) model_drdy = 1'b1;
    end
    if (den && !rst) begin
      t.we = dwe;
      t.a  = daddr;
      t.d  = dwe ? di : 16'h0;
      log_q.push_back(t);
      if (dwe) mem[daddr] = di;
      else do_q = mem[daddr];
      if (!dwe && rd_n == hang_rd) begin
        pend = 0;
        hang_cyc = cyc;
      end else pend = lat;
      if (!dwe) rd_n++;
    end
    if (pll_rst) begin
      pll_lk = 1'b0;
      lk = 0;
    end else if (!lock_en) pll_lk = 1'b0;
    else if (lk >= lock_dly) pll_lk = 1'b1;
    else lk++;
  end

  task automatic rand_cfg();
    for (int k = 0; k < NR; k++) begin
      cfg_addr[k*7 +: 7]   = 7'(($urandom_range(0, 31) << 2) | k);
      cfg_mask[k*16 +: 16] = 16'($urandom);
      cfg_data[k*16 +: 16] = 16'($urandom);
    end
  endtask

  // Expected DRP traffic: per entry a read then a merged write, in order
  task automatic build_exp();
    logic [15:0] m [128];
    logic [6:0]  a;
    logic [15:0] mk, dt, v;
    txn_t t;
    m = mem;
    exp_q.delete();
    for (int k = 0; k < NR; k++) begin
      a  = cfg_addr[k*7 +: 7];
      mk = cfg_mask[k*16 +: 16];
      dt = cfg_data[k*16 +: 16];
      v  = (m[a] & mk) | (dt & ~mk);
      t = '{we: 1'b0, a: a, d: 16'h0};
      exp_q.push_back(t);
      t = '{we: 1'b1, a: a, d: v};
      exp_q.push_back(t);
      m[a] = v;
    end
  endtask

  task automatic clear_run();
    log_q.delete();
    rd_n = 0;
    den_viol = 0;
    dwe_viol = 0;
    done_n = 0;
    hold_n = 0;
    hold_at_den = -1;
    hang_cyc = -1;
    done_cyc = -1;
    rel_cyc = -1;
  endtask

  task automatic run(input int budget, output bit ok);
    int n;
    @(negedge clk);
    clear_run();
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    err_at_start = err;
    n = 1;
    ok = 1'b0;
    while (n < budget && !ok) begin
      if (done) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  function automatic int txn_bad(input int upto);
    int bad;
    bad = (log_q.size() != upto) ? 1 : 0;
    for (int i = 0; i < upto; i++)
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    settle(3);
    nchk++;
    if ({busy, done, err, code, den, dwe, pll_rst, locked} !== 9'h0) begin
      nfail++;
      $display("FAIL reset_ctrl: got %b want 0",
               {busy, done, err, code, den, dwe, pll_rst, locked});
    end
    nchk++;
    if ({daddr, di} !== 23'h0) begin
      nfail++;
      $display("FAIL reset_drp_bus: got %h want 0", {daddr, di});
    end
    rst = 1'b0;
    settle(20);
    nchk++;
    if (locked !== 1'b1) begin
      nfail++;
      $display("FAIL idle_locked: got %b want 1", locked);
    end
  endtask

  task automatic test_single();
    bit ok;
    int bad;
    rand_cfg();
    cfg_addr[6:0]  = 7'h08;
    cfg_mask[15:0] = 16'h1000;
    cfg_data[15:0] = 16'h0145;
    mem[8'h08] = 16'hFFFF;
    lat = 3;
    build_exp();
    run(500, ok);
    nchk++;
    if (!ok) begin
      nfail++;
      $display("FAIL single_done: got timeout want done");
    end
    nchk++;
    if ({err, code, busy, locked, pll_rst} !== 5'b00010) begin
      nfail++;
      $display("FAIL single_status: got %b want 00010",
               {err, code, busy, locked, pll_rst});
    end
    settle(3);
    nchk++;
    if (log_q.size() < 2 || log_q[1].d !== 16'h1145) begin
      nfail++;
      $display("FAIL single_wdata: got %h want 1145",
               (log_q.size() < 2) ? 16'hxxxx : log_q[1].d);
    end
    bad = txn_bad(2 * NR);
    nchk++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL single_txns: got %0d bad want 0", bad);
    end
    nchk++;
    if (hold_at_den < RH || done_n != 1) begin
      nfail++;
      $display("FAIL single_hold_done: got hold %0d done %0d want >=%0d 1",
               hold_at_den, done_n, RH);
    end
  endtask

  task automatic test_multi();
    bit ok;
    int bad;
    for (int it = 0; it < 4; it++) begin
      rand_cfg();
      lat = $urandom_range(1, 6);
      lock_dly = $urandom_range(2, 30);
      build_exp();
      run(800, ok);
      nchk++;
      if (!ok || err !== 1'b0 || locked !== 1'b1) begin
        nfail++;
        $display("FAIL multi_done it%0d: got ok %0b err %b lk %b want 1 0 1",
                 it, ok, err, locked);
      end
      settle(3);
      bad = txn_bad(2 * NR);
      nchk++;
      if (bad != 0) begin
        nfail++;
        $display("FAIL multi_txns it%0d: got %0d bad want 0", it, bad);
      end
      nchk++;
      if (den_viol != 0 || dwe_viol != 0 || done_n != 1 || hold_at_den < RH)
      begin
        nfail++;
        $display("FAIL multi_proto it%0d: got %0d %0d %0d %0d want 0 0 1 >=%0d",
                 it, den_viol, dwe_viol, done_n, hold_at_den, RH);
      end
    end
    lock_dly = 10;
  endtask

  task automatic test_drdy_timeout();
    bit ok;
    int bad;
    rand_cfg();
    lat = $urandom_range(1, 5);
    hang_rd = 2;
    build_exp();
    run(1000, ok);
    nchk++;
    if (!ok || code !== 2'd1 || err !== 1'b1) begin
      nfail++;
      $display("FAIL drdy_to_code: got ok %0b code %0d err %b want 1 1 1",
               ok, code, err);
    end
    nchk++;
    if (pll_rst !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL drdy_to_outs: got rst %b busy %b want 0 0",
               pll_rst, busy);
    end
    settle(3);
    nchk++;
    if (done_n != 1 || done_cyc - hang_cyc != DT + 1) begin
      nfail++;
      $display("FAIL drdy_to_timing: got done %0d dly %0d want 1 %0d",
               done_n, done_cyc - hang_cyc, DT + 1);
    end
    bad = txn_bad(5);
    nchk++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL drdy_to_txns: got %0d bad want 0", bad);
    end
    hang_rd = -1;
    settle(10);
    build_exp();
    run(800, ok);
    nchk++;
    if (err_at_start !== 1'b0 || !ok || err !== 1'b0 || code !== 2'd0) begin
      nfail++;
      $display("FAIL err_clear: got %b %0b %b %0d want 0 1 0 0",
               err_at_start, ok, err, code);
    end
  endtask

  task automatic test_lock_timeout();
    bit ok;
    int bad;
    rand_cfg();
    lat = 2;
    lock_en = 1'b0;
    build_exp();
    run(2000, ok);
    nchk++;
    if (!ok || code !== 2'd2 || err !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL lock_to: got ok %0b code %0d err %b busy %b want 1 2 1 0",
               ok, code, err, busy);
    end
    settle(3);
    nchk++;
    if (done_cyc - rel_cyc != LT + 1) begin
      nfail++;
      $display("FAIL lock_to_timing: got %0d want %0d",
               done_cyc - rel_cyc, LT + 1);
    end
    bad = txn_bad(2 * NR);
    nchk++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL lock_to_txns: got %0d bad want 0", bad);
    end
    lock_en = 1'b1;
    settle(30);
  endtask

  task automatic test_busy_start_stray();
    bit ok;
    int bad;
    clear_run();
    stray = 1'b1;
    settle(3);
    stray = 1'b0;
    settle(3);
    nchk++;
    if (log_q.size() != 0 || busy !== 1'b0 || done_n != 0) begin
      nfail++;
      $display("FAIL stray_drdy: got txns %0d busy %b done %0d want 0 0 0",
               log_q.size(), busy, done_n);
    end
    rand_cfg();
    lat = $urandom_range(1, 4);
    build_exp();
    spam = 1'b1;
    run(800, ok);
    spam = 1'b0;
    settle(6);
    bad = txn_bad(2 * NR);
    nchk++;
    if (!ok || bad != 0 || done_n != 1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL busy_start: got ok %0b bad %0d done %0d busy %b want 1 0 1 0",
               ok, bad, done_n, busy);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    int nw, n, bad;
    rand_cfg();
    lat = 5;
    @(negedge clk);
    clear_run();
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    nw = 0;
    n = 0;
    while (nw < 2 && n < 300) begin
      @(negedge clk);
      n++;
      if (den && dwe) nw++;
    end
    @(negedge clk);
    nchk++;
    if (nw != 2 || pll_rst !== 1'b1 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL rst_mid_reach: got nw %0d rst %b busy %b want 2 1 1",
               nw, pll_rst, busy);
    end
    #1 rst = 1'b1;
    #1;
    nchk++;
    if ({busy, done, err, code, den, dwe, pll_rst, locked, daddr, di}
        !== 32'h0) begin
      nfail++;
      $display("FAIL rst_mid_outs: got %h want 0",
               {busy, done, err, code, den, dwe, pll_rst, locked, daddr, di});
    end
    @(negedge clk);
    nchk++;
    if (pll_rst !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL rst_mid_next: got rst %b busy %b want 0 0", pll_rst, busy);
    end
    rst = 1'b0;
    settle(20);
    lat = $urandom_range(1, 4);
    build_exp();
    run(800, ok);
    settle(3);
    bad = txn_bad(2 * NR);
    nchk++;
    if (!ok || bad != 0 || done_n != 1) begin
      nfail++;
      $display("FAIL rst_mid_rerun: got ok %0b bad %0d done %0d want 1 0 1",
               ok, bad, done_n);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    test_reset();
    test_single();
    test_multi();
    test_drdy_timeout();
    test_lock_timeout();
    test_busy_start_stray();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pll_drp_reconfig_ctrl.md
Name: pll_drp_reconfig_ctrl

Overview:
- Sequences run-time reconfiguration of the system PLL (PLLE2_ADV) through its Dynamic Reconfiguration Port (DRP).
- On a start request it holds the PLL in reset and performs NumRegs read-modify-write DRP transactions from a configuration table. It then releases reset and waits for lock, reporting done or error.
- Sits next to the clock generator. It runs on the always-present input-derived clock, which is also the DRP DCLK.

Parameters:
- NumRegs, 4, number of DRP register updates per reconfiguration (1..32).
- RstHoldCycles, 4, minimum cycles pll_rst_o is held before the first DRP access.
- DrdyTimeout, 64, maximum cycles to wait for drp_drdy_i after each den pulse.
- LockTimeout, 100000, maximum cycles to wait for synchronised lock after reset release.

Ports:
- clk_i  in  1  clock; also drives PLL DCLK externally.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request reconfiguration; accepted only in IDLE.
- cfg_addr_i  in  NumRegs*7  per-entry DRP address; entry k occupies bits [7k+6:7k].
- cfg_mask_i  in  NumRegs*16  per-entry keep mask; a 1 bit retains the old value.
- cfg_data_i  in  NumRegs*16  per-entry new data; only bits where the mask is 0 are used.
- busy_o  out  1  high from start acceptance until DONE/ERROR.
- done_o  out  1  one-cycle pulse at completion, whether success or error.
- err_o  out  1  sticky error flag; cleared when the next start is accepted.
- err_code_o  out  2  0=none, 1=DRDY timeout, 2=lock timeout.
- locked_o  out  1  synchronised PLL lock AND NOT busy_o.
- drp_daddr_o  out  7  DRP address.
- drp_den_o  out  1  DRP enable, one-cycle pulse.
- drp_dwe_o  out  1  DRP write enable; asserted only together with den.
- drp_di_o  out  16  DRP write data.
- drp_do_i  in  16  DRP read data; valid when drdy is high.
- drp_drdy_i  in  1  DRP transaction complete.
- pll_rst_o  out  1  PLL reset.
- pll_locked_i  in  1  raw PLL LOCKED; asynchronous to clk_i.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, index 0, lock synchroniser 0.
  - pll_rst_o is NOT asserted by rst_i. System reset must not reset the PLL (keeps debug/ILA clocks alive).
- pll_locked_i passes through a 2-flop synchroniser, giving lock_s. locked_o = lock_s & ~busy_o.
- States and transitions:
  - IDLE: start_i=1 → HOLD_RST. Accepting start clears err_o/err_code_o, sets busy_o, sets idx=0 and cnt=0.
  - HOLD_RST: pll_rst_o=1; cnt increments. At cnt==RstHoldCycles-1 → RD.
  - RD: drp_den_o=1, drp_dwe_o=0, drp_daddr_o=addr[idx] for one cycle → RD_WAIT, cnt=0.
  - RD_WAIT: on drdy, capture rdata=(drp_do_i & mask[idx]) | (data[idx] & ~mask[idx]) → WR. If cnt reaches DrdyTimeout-1 without drdy → ERROR, code 1.
  - WR: drp_den_o=1, drp_dwe_o=1, drp_daddr_o=addr[idx], drp_di_o=rdata for one cycle → WR_WAIT, cnt=0.
  - WR_WAIT: on drdy, if idx==NumRegs-1 → RELEASE, else idx++ → RD. Timeout as in RD_WAIT.
  - RELEASE: pll_rst_o=0, cnt=0 → WAIT_LOCK.
  - WAIT_LOCK: lock_s=1 → DONE. If cnt reaches LockTimeout-1 → ERROR, code 2.
  - DONE: done_o=1 for one cycle, busy_o=0 → IDLE.
  - ERROR: pll_rst_o=0, err_o=1, done_o=1 for one cycle, busy_o=0 → IDLE.
- pll_rst_o is 1 in HOLD_RST, RD, RD_WAIT, WR and WR_WAIT, and 0 in all other states.
- drp_daddr_o and drp_di_o hold their last values outside den cycles. Checkers treat them as don't-care then.
- drp_drdy_i is ignored outside RD_WAIT/WR_WAIT, including a stray drdy in the same cycle as den.
- start_i is ignored while busy; no queuing.
- cfg_* inputs must be stable while busy_o=1. The block does not register the table.
- Lock in WAIT_LOCK uses lock_s only. The stale lock from before reset is already flushed because HOLD_RST is at least 1 cycle and the PLL drops LOCKED on reset.
- An rst_i mid-operation returns the FSM to IDLE and deasserts pll_rst_o. The PLL then relocks with whatever partial configuration was written. Software must reissue start.
- Counter widths: $clog2 of the largest of RstHoldCycles, DrdyTimeout and LockTimeout, plus 1. idx width is $clog2(NumRegs)+1.

Decomposition:
- Package pll_drp_pkg holds:
  - state enum drp_state_e;
  - err_code_e (ErrNone, ErrDrdyTimeout, ErrLockTimeout);
  - DRP width constants DrpAddrW=7 and DrpDataW=16;
  - PLLE2 register address constants, e.g. ClkOut0Reg1=7'h08, ClkFbOutReg1=7'h14.
- One sub-module, prim_flop_2sync, provides the lock synchroniser.
- Table muxing and the FSM stay in the top module.

Test Plan:
- Single entry, addr=7'h08, mask=16'h1000, data=16'h0145, DRP model returns 16'hFFFF with 3-cycle drdy latency → write di=16'h1145; pll_rst_o high for at least 4 cycles; done_o pulses once lock is modelled; err_o=0; locked_o=1 after done.
- NumRegs=4, distinct addresses → exactly 4 reads and 4 writes in order (R0 W0 R1 W1 …); drp_den_o never high two consecutive cycles; drp_dwe_o only on writes.
- DRP model never asserts drdy on entry 2 → ERROR after 64 cycles; err_code_o=1; pll_rst_o=0; done_o single pulse; next start clears err_o.
- PLL model never locks → err_code_o=2 after 100000 cycles in WAIT_LOCK; busy_o falls with done_o.
- start_i pulsed while busy, plus stray drdy in IDLE → no extra transactions, no state change.
- rst_i asserted during WR_WAIT → next cycle pll_rst_o=0, busy_o=0, all outputs at reset values; a subsequent start completes normally.
